// File: rtl/tour_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tour_pkg
//  Description : Shared definitions for the knight-tour command generator.
//                Holds the command opcodes, heading codes, host response
//                codes, the tour state enum and a one-hot test helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tour_pkg;

   // Command opcodes (upper nibble of the 16-bit command word)
   localparam logic [3:0] OP_VERT = 4'h4;
   localparam logic [3:0] OP_HORZ = 4'h5;

   // Headings (middle byte of the command word)
   localparam logic [7:0] HDG_N = 8'h7F;
   localparam logic [7:0] HDG_S = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_E = 8'hBF;

   // Response bytes returned to the host
   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_BUSY = 8'h5A;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEG1  = 3'd1,
      HOLD1 = 3'd2,
      LEG2  = 3'd3,
      HOLD2 = 3'd4
   } tour_state_e;

   // True when exactly one bit of v is set
   function automatic logic is_onehot8(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tour_move_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tour_move_decode
//  Description : Combinational translation of a one-hot knight move into a
//                single-leg movement command {opcode, heading, squares}.
//  Ports       : move_i   [7:0]  one-hot knight move
//                vert_i          1 = vertical leg, 0 = horizontal leg
//                invert_i        1 = reverse heading (undo direction)
//                cmd_o    [15:0] command word
//  Revision    : 1.0  initial release
// ============================================================================
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0]  move_i,
   input  logic        vert_i,
   input  logic        invert_i,
   output logic [15:0] cmd_o
);

   logic [3:0] opcode;
   logic [7:0] heading_raw;
   logic [7:0] heading;
   logic [3:0] squares;

   always_comb begin
      if (vert_i) begin
         opcode      = OP_VERT;
         heading_raw = (|move_i[6:3]) ? HDG_N : HDG_S;
         squares     = (|{move_i[5:4], move_i[1:0]}) ? 4'd2 : 4'd1;
      end else begin
         opcode      = OP_HORZ;
         heading_raw = (|move_i[4:1]) ? HDG_W : HDG_E;
         squares     = (|{move_i[7:6], move_i[3:2]}) ? 4'd2 : 4'd1;
      end
   end

   // Undo drives the same leg in the opposite direction: swap N/S and W/E
   always_comb begin
      heading = heading_raw;
      if (invert_i) begin
         unique case (heading_raw)
            HDG_N:   heading = HDG_S;
            HDG_S:   heading = HDG_N;
            HDG_W:   heading = HDG_E;
            HDG_E:   heading = HDG_W;
            default: heading = heading_raw;
         endcase
      end
   end

   assign cmd_o = {opcode, heading, squares};

endmodule
`default_nettype wire

// File: rtl/tour_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tour_cmd_gen
//  Description : Replays (or undoes) a knight's tour as a stream of leg
//                commands. Each move becomes two commands, one vertical and
//                one horizontal, handed to the command processor with a
//                cmd_rdy / clr_cmd_rdy / send_resp handshake. In IDLE the
//                host command channel passes straight through.
//  Ports       : clk, rst                 clock, sync active-high reset
//                start_tour, reverse      start pulse, direction (1 = undo)
//                abort                    terminate tour immediately
//                move [7:0]               one-hot move at mv_indx
//                cmd_UART, cmd_rdy_UART   host command channel
//                clr_cmd_rdy, send_resp   command processor handshake
//                cmd, cmd_rdy             command to command processor
//                mv_indx                  current move index
//                resp [7:0]               response byte to host
//                busy, tour_done, move_err status
//  Revision    : 1.0  initial release
// ============================================================================
module tour_cmd_gen
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = $clog2(NUM_MOVES),
   parameter int CMD_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_tour,
   input  logic             reverse,
   input  logic             abort,
   input  logic [7:0]       move,
   input  logic [CMD_W-1:0] cmd_UART,
   input  logic             cmd_rdy_UART,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_rdy,
   output logic [IDX_W-1:0] mv_indx,
   output logic [7:0]       resp,
   output logic             busy,
   output logic             tour_done,
   output logic             move_err
);

   localparam logic [IDX_W-1:0] IDX_MIN = '0;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_MOVES - 1);

   tour_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             rev_q, rev_d;

   logic             in_leg1;
   logic             leg_vert;
   logic             at_last;
   logic             move_ok;
   logic [15:0]      leg_cmd;

   // Forward: first leg vertical. Undo retraces the move backwards, so the
   // horizontal leg comes first.
   assign in_leg1  = (state_q == LEG1) || (state_q == HOLD1);
   assign leg_vert = in_leg1 ^ rev_q;
   assign at_last  = (idx_q == (rev_q ? IDX_MIN : IDX_MAX));
   assign move_ok  = is_onehot8(move);
   assign mv_indx  = idx_q;

   tour_move_decode u_decode (
      .move_i   (move),
      .vert_i   (leg_vert),
      .invert_i (rev_q),
      .cmd_o    (leg_cmd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rev_q   <= rev_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rev_d     = rev_q;
      cmd       = CMD_W'(leg_cmd);
      cmd_rdy   = 1'b0;
      resp      = RESP_BUSY;
      busy      = 1'b1;
      tour_done = 1'b0;
      move_err  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd     = cmd_UART;
            cmd_rdy = cmd_rdy_UART;
            resp    = RESP_DONE;
            busy    = 1'b0;
            if (start_tour) begin
               rev_d   = reverse;
               idx_d   = reverse ? IDX_MAX : IDX_MIN;
               state_d = LEG1;
            end
         end
         LEG1: begin
            // A corrupt move is caught before any command is offered
            if (!move_ok) begin
               move_err = 1'b1;
               state_d  = IDLE;
            end else begin
               cmd_rdy = 1'b1;
               if (clr_cmd_rdy) state_d = HOLD1;
            end
         end
         HOLD1: begin
            if (send_resp) state_d = LEG2;
         end
         LEG2: begin
            cmd_rdy = 1'b1;
            if (at_last) resp = RESP_DONE;
            if (clr_cmd_rdy) state_d = HOLD2;
         end
         HOLD2: begin
            if (at_last) resp = RESP_DONE;
            if (send_resp) begin
               if (at_last) begin
                  tour_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  idx_d   = rev_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
                  state_d = LEG1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // abort wins over everything: index and direction are frozen
      if (abort) begin
         state_d   = IDLE;
         idx_d     = idx_q;
         rev_d     = rev_q;
         tour_done = 1'b0;
         move_err  = 1'b0;
      end
   end

endmodule
`default_nettype wire
